poly_mult_ctrl: RTL and testbench

Parametrised sequencer for the schoolbook polynomial multiplier datapath. It drives the two circular shift registers (CSR1 holds operand A, CSR2 holds operand B) and the coefficient accumulator through N×N multiply-accumulate steps. It uses a start/busy/done handshake, supports a synchronous abort, and selects cyclic (mod x^N−1) or negacyclic (mod x^N+1) reduction per run. It replaces the fixed-length CSR control unit and sits between the top-level command interface and the CSR/MAC datapath.

---
 rtl/poly_mult_ctrl.sv | 129 ++++++++++++
 tb/tb_poly_mult_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/poly_mult_ctrl.sv
// Sequencer for the schoolbook polynomial multiplier: walks (i,j) over N*N MAC
// steps, strobing the two CSRs and the accumulator, with cyclic/negacyclic reduction.
module poly_mult_ctrl #(
  parameter  int N     = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode_neg,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             csr1_load,
  output logic             csr1_en,
  output logic             csr2_load,
  output logic             csr2_en,
  output logic             acc_clr,
  output logic             acc_en,
  output logic             acc_neg,
  output logic [IDX_W-1:0] idx_i,
  output logic [IDX_W-1:0] idx_j
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  state_t           state, state_nxt;
  logic             mode_q;
  logic             last_j, last_step;

  // A product term wraps past x^N when i+j >= N; the sum gets one extra bit.
  function automatic logic wraps_past_n(input logic [IDX_W-1:0] i,
                                        input logic [IDX_W-1:0] j);
    logic [IDX_W:0] sum;
    sum = {1'b0, i} + {1'b0, j};
    return (sum >= (IDX_W+1)'(N));
  endfunction

  assign last_j    = (idx_j == LAST);
  assign last_step = last_j && (idx_i == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      mode_q <= 1'b0;
      idx_i  <= '0;
      idx_j  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          idx_i <= '0;
          idx_j <= '0;
          if (start) mode_q <= mode_neg;
        end
        LOAD: begin
          idx_i <= '0;
          idx_j <= '0;
        end
        RUN: begin
          if (abort) begin
            idx_i <= '0;
            idx_j <= '0;
          end else if (last_step) begin
            // Indices hold N-1 through DONE.
            idx_i <= idx_i;
            idx_j <= idx_j;
          end else if (last_j) begin
            idx_j <= '0;
            idx_i <= idx_i + 1'b1;
          end else begin
            idx_j <= idx_j + 1'b1;
          end
        end
        default: begin
          idx_i <= '0;
          idx_j <= '0;
        end
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    csr1_load = 1'b0;
    csr1_en   = 1'b0;
    csr2_load = 1'b0;
    csr2_en   = 1'b0;
    acc_clr   = 1'b0;
    acc_en    = 1'b0;
    acc_neg   = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        busy      = 1'b1;
        csr1_load = 1'b1;
        csr2_load = 1'b1;
        acc_clr   = 1'b1;
        state_nxt = abort ? IDLE : RUN;
      end
      RUN: begin
        busy    = 1'b1;
        acc_en  = 1'b1;
        csr2_en = 1'b1;
        csr1_en = last_j;
        acc_neg = mode_q & wraps_past_n(idx_i, idx_j);
        if (abort)          state_nxt = IDLE;
        else if (last_step) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_poly_mult_ctrl.sv
// Directed bench for poly_mult_ctrl: N=4 and N=8 instances, per-cycle output
// vectors compared against a cycle-indexed expectation plus strobe totals.
module tb_poly_mult_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset4 = 1'b1, start4 = 1'b0, mode4 = 1'b0, abort4 = 1'b0;
  logic reset8 = 1'b1, start8 = 1'b0, mode8 = 1'b0, abort8 = 1'b0;

  logic busy4, done4, c1l4, c1e4, c2l4, c2e4, aclr4, aen4, aneg4;
  logic [1:0] ii4, ij4;
  logic busy8, done8, c1l8, c1e8, c2l8, c2e8, aclr8, aen8, aneg8;
  logic [2:0] ii8, ij8;

  poly_mult_ctrl #(.N(4)) dut4 (
    .clk(clk), .reset(reset4), .start(start4), .mode_neg(mode4), .abort(abort4),
    .busy(busy4), .done(done4), .csr1_load(c1l4), .csr1_en(c1e4),
    .csr2_load(c2l4), .csr2_en(c2e4), .acc_clr(aclr4), .acc_en(aen4),
    .acc_neg(aneg4), .idx_i(ii4), .idx_j(ij4)
  );

  poly_mult_ctrl #(.N(8)) dut8 (
    .clk(clk), .reset(reset8), .start(start8), .mode_neg(mode8), .abort(abort8),
    .busy(busy8), .done(done8), .csr1_load(c1l8), .csr1_en(c1e8),
    .csr2_load(c2l8), .csr2_en(c2e8), .acc_clr(aclr8), .acc_en(aen8),
    .acc_neg(aneg8), .idx_i(ii8), .idx_j(ij8)
  );

  // [14]busy [13]done [12]csr1_load [11]csr1_en [10]csr2_load [9]csr2_en
  // [8]acc_clr [7]acc_en [6]acc_neg [5:3]idx_i [2:0]idx_j
  logic [31:0] obs4, obs8;
  assign obs4 = {17'b0, busy4, done4, c1l4, c1e4, c2l4, c2e4, aclr4, aen4, aneg4,
                 1'b0, ii4, 1'b0, ij4};
  assign obs8 = {17'b0, busy8, done8, c1l8, c1e8, c2l8, c2e8, aclr8, aen8, aneg8,
                 ii8, ij8};

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] obs(input int n);
    return (n == 4) ? obs4 : obs8;
  endfunction

  task automatic drive(input int n, input logic s, input logic m, input logic a,
                       input logic r);
    if (n == 4) begin
      start4 = s; mode4 = m; abort4 = a; reset4 = r;
    end else begin
      start8 = s; mode8 = m; abort8 = a; reset8 = r;
    end
  endtask

  // Expected outputs in cycle c of a run (c=1 is LOAD); c outside 1..n*n+2 is idle.
  function automatic logic [31:0] exp_vec(input int n, input int c, input logic neg);
    logic [31:0] v;
    int k, i, j;
    v = '0;
    if (c == 1) begin
      v[14] = 1'b1; v[12] = 1'b1; v[10] = 1'b1; v[8] = 1'b1;
    end else if (c >= 2 && c <= n*n + 1) begin
      k = c - 2; i = k / n; j = k % n;
      v[14] = 1'b1; v[9] = 1'b1; v[7] = 1'b1;
      v[11] = (j == n - 1);
      v[6] = neg && (i + j >= n);
      v[5:3] = 3'(i);
      v[2:0] = 3'(j);
    end else if (c == n*n + 2) begin
      v[13] = 1'b1;
      v[5:3] = 3'(n - 1);
      v[2:0] = 3'(n - 1);
    end
    return v;
  endfunction

  // Issues one start, then checks every cycle for `periods` run lengths (each
  // n*n+3 cycles incl. one idle). Optional abort/reset after cycle kill_cyc.
  // Expected totals < 0 are not checked.
  task automatic run(input int n, input logic neg, input int kill_cyc,
                     input logic kill_rst, input logic hold, input int periods,
                     input int e_c1, input int e_c2, input int e_acc,
                     input int e_neg, input int e_done);
    int per, c1, c2, ac, ng, dn;
    logic killed, m_after;
    logic [31:0] g, e;
    per = n*n + 3;
    c1 = 0; c2 = 0; ac = 0; ng = 0; dn = 0;
    killed = 1'b0;
    m_after = hold ? neg : ~neg;
    drive(n, 1'b1, neg, 1'b0, 1'b0);
    tick();
    drive(n, hold, m_after, 1'b0, 1'b0);
    for (int c = 1; c <= per*periods; c++) begin
      e = killed ? 32'd0 : exp_vec(n, ((c - 1) % per) + 1, neg);
      g = obs(n);
      check($sformatf("n%0d_neg%0d_c%0d", n, neg, c), g, e);
      c1 += int'(g[11]); c2 += int'(g[9]); ac += int'(g[7]);
      ng += int'(g[6]);  dn += int'(g[13]);
      if (c == kill_cyc) begin
        drive(n, 1'b0, m_after, ~kill_rst, kill_rst);
        killed = 1'b1;
      end else if (killed || c == per*periods) begin
        drive(n, 1'b0, m_after, 1'b0, 1'b0);
      end
      tick();
    end
    drive(n, 1'b0, 1'b0, 1'b0, 1'b0);
    if (e_c1 >= 0)   check($sformatf("n%0d_csr1_en_cnt", n), 32'(c1), 32'(e_c1));
    if (e_c2 >= 0)   check($sformatf("n%0d_csr2_en_cnt", n), 32'(c2), 32'(e_c2));
    if (e_acc >= 0)  check($sformatf("n%0d_acc_en_cnt", n), 32'(ac), 32'(e_acc));
    if (e_neg >= 0)  check($sformatf("n%0d_acc_neg_cnt", n), 32'(ng), 32'(e_neg));
    if (e_done >= 0) check($sformatf("n%0d_done_cnt", n), 32'(dn), 32'(e_done));
  endtask

  initial begin
    @(negedge clk);
    // Reset held two cycles, then five quiet idle cycles.
    for (int k = 0; k < 2; k++) begin
      tick();
      check($sformatf("rst_hold%0d", k), obs4, 32'd0);
    end
    reset4 = 1'b0;
    reset8 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("idle%0d", k), obs4, 32'd0);
    end
    check("idle_n8", obs8, 32'd0);

    run(4, 1'b0, 0, 1'b0, 1'b0, 1, 4, 16, 16, 0, 1);
    run(4, 1'b1, 0, 1'b0, 1'b0, 1, 4, 16, 16, 6, 1);

    // Abort after cycle 8, then a fresh complete run.
    run(4, 1'b0, 8, 1'b0, 1'b0, 1, 1, 7, 7, 0, 0);
    run(4, 1'b0, 0, 1'b0, 1'b0, 1, 4, 16, 16, 0, 1);

    // Reset after cycle 10 of a negacyclic run.
    run(4, 1'b1, 10, 1'b1, 1'b0, 1, -1, -1, -1, -1, 0);

    // Start held high: back-to-back runs, LOAD again in cycle 20.
    run(4, 1'b1, 0, 1'b0, 1'b1, 2, 8, 32, 32, 12, 2);

    // Abort while idle is ignored and does not block a start.
    drive(4, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    check("abort_idle_load", obs4, exp_vec(4, 1, 1'b0));
    drive(4, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    drive(4, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_after_load", obs4, 32'd0);

    run(8, 1'b0, 0, 1'b0, 1'b0, 1, 8, 64, 64, 0, 1);
    run(8, 1'b1, 0, 1'b0, 1'b0, 1, 8, 64, 64, 28, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
